// File: rtl/qlm_mult_pipe.sv
// qlm_mult_pipe: pipelined unsigned WxW -> 2W multiplier with a per-operation
// choice between the exact product and a Mitchell log-based approximation.
// Valid/ready streaming on both sides; a single advance enable stalls the
// whole pipeline when the output is held. op_count tallies output handshakes.
//
// Register ranks: S1 (operands) -> S2 (partial products / log terms)
//                 -> S3 (sum / mantissa + shift) -> output registers.
`timescale 1ns/1ps

module qlm_mult_pipe #(
  parameter int W     = 16,
  parameter int Q     = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [W-1:0]       y,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     p_out,
  output logic               out_mode,
  output logic [CNT_W-1:0]   op_count
);

  localparam int LO_W = W / 2;          // low half of y
  localparam int HI_W = W - LO_W;       // high half of y
  localparam int KW   = $clog2(W);      // leading-one index width
  localparam int PW   = 2 * W;          // product width
  localparam int MW   = Q + 2;          // approx mantissa width
  localparam int EW   = PW + Q + 2;     // antilog shift headroom

  // Index of the most significant set bit (0 when v == 0; caller masks that case).
  function automatic logic [KW-1:0] lead_one(input logic [W-1:0] v);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) r = KW'(i);
    end
    return r;
  endfunction

  // Bits below the leading one, normalised to a Q-bit fraction (truncated).
  function automatic logic [Q-1:0] frac_of(input logic [W-1:0] v, input logic [KW-1:0] k);
    logic [W+Q-1:0] t;
    t = {v ^ (W'(1) << k), {Q{1'b0}}} >> k;
    return t[Q-1:0];
  endfunction

  logic adv;

  // Stage 1 registers
  logic           s1_valid;
  logic [W-1:0]   s1_x, s1_y;
  logic           s1_mode;

  // Stage 2 registers
  logic                 s2_valid;
  logic                 s2_mode;
  logic [W+LO_W-1:0]    s2_pp_lo;
  logic [W+HI_W-1:0]    s2_pp_hi;
  logic [KW-1:0]        s2_kx, s2_ky;
  logic [Q-1:0]         s2_fx, s2_fy;
  logic                 s2_zero;

  // Stage 3 registers
  logic                 s3_valid;
  logic                 s3_mode;
  logic [PW-1:0]        s3_val;     // exact product, or approx mantissa zero-extended
  logic [KW:0]          s3_sh;      // kx + ky

  // Combinational next-stage values
  logic [W+LO_W-1:0]    pp_lo_d;
  logic [W+HI_W-1:0]    pp_hi_d;
  logic [KW-1:0]        kx_d, ky_d;
  logic [Q-1:0]         fx_d, fy_d;
  logic [PW-1:0]        sum_d;
  logic [Q:0]           s_d;
  logic [MW-1:0]        m_d;
  logic [EW-1:0]        wide_d;
  logic [PW-1:0]        p_d;

  // The whole pipeline moves unless a valid result is waiting on the consumer.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // S1: capture the operand pair (a bubble enters when in_valid is low).
  // NOTE: all registers are written with <= so every stage samples the
  // previous-cycle value of its source; = here would collapse stages.
  // NOTE: data registers are reset too -- p_out must read 0 after reset, and
  // the design holds no memory array that would make a reset costly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_mode  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_x     <= x;
      s1_y     <= y;
      s1_mode  <= mode;
    end
  end

  // S1 -> S2 work: both partial products and both log terms are formed every cycle.
  // NOTE: every output of an always_comb gets a value on every path (here
  // unconditionally); a missed branch would infer a latch.
  always_comb begin
    pp_lo_d = (W+LO_W)'(s1_x) * (W+LO_W)'(s1_y[LO_W-1:0]);
    pp_hi_d = (W+HI_W)'(s1_x) * (W+HI_W)'(s1_y[W-1:LO_W]);
    kx_d    = lead_one(s1_x);
    ky_d    = lead_one(s1_y);
    fx_d    = frac_of(s1_x, kx_d);
    fy_d    = frac_of(s1_y, ky_d);
  end

  // S2: hold partial products and log terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_pp_lo <= '0;
      s2_pp_hi <= '0;
      s2_kx    <= '0;
      s2_ky    <= '0;
      s2_fx    <= '0;
      s2_fy    <= '0;
      s2_zero  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s2_pp_lo <= pp_lo_d;
      s2_pp_hi <= pp_hi_d;
      s2_kx    <= kx_d;
      s2_ky    <= ky_d;
      s2_fx    <= fx_d;
      s2_fy    <= fy_d;
      s2_zero  <= (s1_x == '0) || (s1_y == '0);
    end
  end

  // S2 -> S3 work: exact final add, or approx mantissa M and shift kx+ky.
  always_comb begin
    sum_d = PW'(s2_pp_lo) + (PW'(s2_pp_hi) << LO_W);
    s_d   = (Q+1)'(s2_fx) + (Q+1)'(s2_fy);
    if (s2_zero)
      m_d = '0;
    else if (!s_d[Q])
      m_d = {2'b01, s_d[Q-1:0]};     // s < 2^Q: M = 2^Q + s
    else
      m_d = {s_d, 1'b0};             // s >= 2^Q: M = 2s
  end

  // S3: hold the exact product or the approx mantissa with its shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_mode  <= 1'b0;
      s3_val   <= '0;
      s3_sh    <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_mode  <= s2_mode;
      s3_val   <= s2_mode ? PW'(m_d) : sum_d;
      s3_sh    <= (KW+1)'(s2_kx) + (KW+1)'(s2_ky);
    end
  end

  // S3 -> output work: antilog is M * 2^(kx+ky) / 2^Q, truncated.
  always_comb begin
    wide_d = EW'(s3_val[MW-1:0]) << s3_sh;
    p_d    = s3_mode ? PW'(wide_d >> Q) : s3_val;
  end

  // Output registers: bubbles advance out_valid but never overwrite p_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_out     <= '0;
      out_mode  <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        p_out    <= p_d;
        out_mode <= s3_mode;
      end
    end
  end

  // Completed-operation counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (out_valid && out_ready)
      op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_qlm_mult_pipe.sv
// tb_qlm_mult_pipe: directed and random stimulus against a behavioural
// multiply/Mitchell model; results are matched in order through a queue.
`timescale 1ns/1ps

module tb_qlm_mult_pipe;

  localparam int W     = 16;
  localparam int Q     = 6;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x, y;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   p_out;
  logic             out_mode;
  logic [CNT_W-1:0] op_count;

  qlm_mult_pipe #(.W(W), .Q(Q), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_out     (p_out),
    .out_mode  (out_mode),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    longint unsigned p;
    bit              m;
  } exp_t;

  exp_t            exp_q[$];
  int              n_assert = 0;
  int              n_fail   = 0;
  int              n_hs     = 0;
  int              n_stall  = 0;
  bit              held_prev = 0;
  logic [2*W-1:0]  p_prev;
  logic            m_prev;
  bit              acc_last, out_last;
  int              acc_edge, out_edge;

  // Reference: exact product, or Mitchell approximation from its definition.
  function automatic longint unsigned ref_p(longint unsigned a, longint unsigned b, bit m);
    longint unsigned ka, kb, fa, fb, s, mm;
    if (!m) return a * b;
    if (a == 0 || b == 0) return 0;
    ka = 0;
    while ((a >> (ka + 1)) != 0) ka++;
    kb = 0;
    while ((b >> (kb + 1)) != 0) kb++;
    fa = ((a - (64'd1 << ka)) * (64'd1 << Q)) / (64'd1 << ka);
    fb = ((b - (64'd1 << kb)) * (64'd1 << Q)) / (64'd1 << kb);
    s  = fa + fb;
    mm = (s < (64'd1 << Q)) ? (64'd1 << Q) + s : 2 * s;
    return (mm << (ka + kb)) >> Q;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check what the
  // DUT presents ahead of the next rising edge, where handshakes take effect.
  task automatic drive(bit v, int unsigned a, int unsigned b, bit m, bit ordy,
                       bit lit = 0, longint unsigned lit_p = 0);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    x         = a[W-1:0];
    y         = b[W-1:0];
    mode      = m;
    out_ready = ordy;
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
    check("op_count", {48'd0, op_count}, 64'(n_hs % (1 << CNT_W)));
    if (held_prev) begin
      check("p_hold", {32'd0, p_out}, {32'd0, p_prev});
      check("mode_hold", {63'd0, out_mode}, {63'd0, m_prev});
    end
    out_last = 0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("p_out", {32'd0, p_out}, e.p);
        check("out_mode", {63'd0, out_mode}, {63'd0, e.m});
      end
      n_hs++;
      out_last = 1;
      out_edge = cyc;
    end
    if (out_valid && !out_ready) n_stall++;
    held_prev = out_valid && !out_ready;
    p_prev    = p_out;
    m_prev    = out_mode;
    acc_last  = v && in_ready;
    if (acc_last) begin
      e.p = lit ? lit_p : ref_p(64'(a), 64'(b), m);
      e.m = m;
      exp_q.push_back(e);
      acc_edge = cyc + 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive(0, 0, 0, 0, 1);
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int unsigned pa, pb;
    bit          pm, pend;
    int          a_e, sent;
    int unsigned bx[6], by[6];

    // Reset state
    rst_n = 0; in_valid = 0; x = 0; y = 0; mode = 0; out_ready = 1;
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_p_out", {32'd0, p_out}, 64'd0);
    check("rst_out_mode", {63'd0, out_mode}, 64'd0);
    check("rst_op_count", {48'd0, op_count}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 1);
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // 1: exact 3*5, latency and first count
    drive(1, 3, 5, 0, 1, 1, 15);
    a_e = acc_edge;
    out_last = 0;
    for (int i = 0; i < 8 && !out_last; i++) drive(0, 0, 0, 0, 1);
    check("latency", 64'(out_edge - a_e), 64'd3);
    drive(0, 0, 0, 0, 1);
    check("op_count_first", {48'd0, op_count}, 64'd1);

    // 2: approx known values
    drive(1, 3, 5, 1, 1, 1, 14);
    drive(1, 255, 255, 1, 1, 1, 64512);
    drain();

    // 3: corners
    drive(1, 0, 65535, 0, 1, 1, 0);
    drive(1, 0, 65535, 1, 1, 1, 0);
    drive(1, 65535, 65535, 0, 1, 1, 64'hFFFE_0001);
    drive(1, 1, 1, 1, 1, 1, 1);
    drive(1, 32768, 32768, 1, 1, 1, 64'd1 << 30);
    drive(1, 65535, 65535, 1, 1);
    drain();

    // 4: backpressure, out_ready low for stream cycles 4..9
    for (int i = 0; i < 6; i++) begin
      bx[i] = $urandom_range(1, 65535);
      by[i] = $urandom_range(1, 65535);
    end
    sent = 0;
    n_stall = 0;
    for (int c = 0; c < 30; c++) begin
      if (sent < 6) drive(1, bx[sent], by[sent], sent[0], !(c >= 4 && c <= 9));
      else          drive(0, 0, 0, 0, !(c >= 4 && c <= 9));
      if (acc_last) sent++;
    end
    check("bp_all_sent", 64'(sent), 64'd6);
    check("bp_stalled", 64'(n_stall > 0), 64'd1);
    drain();

    // 5: alternating modes, back-to-back
    for (int i = 0; i < 16; i++)
      drive(1, $urandom_range(0, 65535), $urandom_range(0, 65535), i[0], 1);
    drain();

    // Random traffic with random backpressure; an offered op is held until taken
    pend = 0;
    for (int c = 0; c < 120; c++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        pa = $urandom_range(0, 65535) >> $urandom_range(0, 15);
        pb = $urandom_range(0, 65535) >> $urandom_range(0, 15);
        pm = 1'($urandom_range(0, 1));
        pend = 1;
      end
      drive(pend, pa, pb, pm, $urandom_range(0, 3) != 0);
      if (acc_last) pend = 0;
    end
    pend = 0;
    drain();

    // 6: reset with two ops in flight
    drive(1, 1234, 4321, 0, 1);
    drive(1, 999, 77, 1, 1);
    drive(0, 0, 0, 0, 1);
    #2;
    rst_n = 0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_op_count", {48'd0, op_count}, 64'd0);
    exp_q.delete();
    n_hs = 0;
    held_prev = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    drive(1, 7, 9, 0, 1, 1, 63);
    a_e = acc_edge;
    out_last = 0;
    for (int i = 0; i < 8 && !out_last; i++) drive(0, 0, 0, 0, 1);
    check("latency_after_reset", 64'(out_edge - a_e), 64'd3);
    drive(0, 0, 0, 0, 1);
    check("op_count_after_reset", {48'd0, op_count}, 64'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
